// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment reader.
// Holds segment patterns, the invalid-digit marker and FSM state codes.
package seg_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_COUNT = 2'd1;
    localparam state_t ST_HELD  = 2'd2;

endpackage

// File: rtl/seven_segment_pattern_to_digit.sv
// Reverse lookup from an active-low segment pattern to a decimal digit.
// Ports: pattern (in, 7b); digit (out, 4b, 4'hF if none); ok (out); blank (out).
module seven_segment_pattern_to_digit
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       ok,
    output logic       blank
);

    always_comb begin
        digit = DIGIT_INVALID;
        ok    = 1'b0;
        blank = 1'b0;
        case (pattern)
            SEG_0:     begin digit = 4'd0; ok = 1'b1; end
            SEG_1:     begin digit = 4'd1; ok = 1'b1; end
            SEG_2:     begin digit = 4'd2; ok = 1'b1; end
            SEG_3:     begin digit = 4'd3; ok = 1'b1; end
            SEG_4:     begin digit = 4'd4; ok = 1'b1; end
            SEG_5:     begin digit = 4'd5; ok = 1'b1; end
            SEG_6:     begin digit = 4'd6; ok = 1'b1; end
            SEG_7:     begin digit = 4'd7; ok = 1'b1; end
            SEG_8:     begin digit = 4'd8; ok = 1'b1; end
            SEG_9:     begin digit = 4'd9; ok = 1'b1; end
            SEG_BLANK: blank = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Captures multiplexed seven-segment display lines into a framed digit word.
// Ports: clk, rst (async high); seg_n[6:0], an_n[N-1:0] sampled display lines;
// digits[4N-1:0], digit_ok[N-1:0], out_valid / out_ready handshake;
// overrun, pattern_err sticky flags. SEVEN_SEGMENT_READER_DP_EN adds dp_n / dp.
module seven_segment_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
`ifdef SEVEN_SEGMENT_READER_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dp,
`endif
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    pattern_err
);

`ifdef SEVEN_SEGMENT_READER_DP_EN
    localparam int PW = NUM_DIGITS + 8;
`else
    localparam int PW = NUM_DIGITS + 7;
`endif
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    // All sampled lines travel together so one compare detects any change
    logic [PW-1:0] in_raw;
    logic [PW-1:0] s1_q, s2_q, prev_q;

`ifdef SEVEN_SEGMENT_READER_DP_EN
    assign in_raw = {dp_n, an_n, seg_n};
`else
    assign in_raw = {an_n, seg_n};
`endif

    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;
    assign an_s  = s2_q[7 +: NUM_DIGITS];
    assign seg_s = s2_q[6:0];

    logic [3:0] dec_digit;
    logic        dec_ok;
    logic        dec_blank;

    seven_segment_pattern_to_digit u_dec (
        .pattern (seg_s),
        .digit   (dec_digit),
        .ok      (dec_ok),
        .blank   (dec_blank)
    );

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] slot_q, slot_d;
    logic [NUM_DIGITS-1:0]   sok_q, sok_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dok_q, dok_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    perr_q, perr_d;
`ifdef SEVEN_SEGMENT_READER_DP_EN
    logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

    logic                  changed;
    logic                  one_hot;
    logic                  cap;
    logic                  load;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] mask_cap;

    assign changed = (s2_q != prev_q);
    assign one_hot = $onehot(~an_s);
    assign sel     = ~an_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        if (changed) begin
            state_d = one_hot ? ST_COUNT : ST_IDLE;
            cnt_d   = one_hot ? 8'd1 : 8'd0;
        end else if (state_q == ST_COUNT) begin
            // Count marks cycles already stable; capture on the following edge
            if (cnt_q == STABLE_C) begin
                cap     = 1'b1;
                state_d = ST_HELD;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        sok_d  = sok_q;
`ifdef SEVEN_SEGMENT_READER_DP_EN
        sdp_d  = sdp_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && sel[i]) begin
                slot_d[i*4 +: 4] = dec_digit;
                sok_d[i]         = dec_ok;
`ifdef SEVEN_SEGMENT_READER_DP_EN
                sdp_d[i]         = ~s2_q[PW-1];
`endif
            end
        end
        mask_cap = mask_q | (cap ? sel : '0);
        load     = &mask_cap;
        mask_d   = load ? '0 : mask_cap;
        perr_d   = perr_q | (cap & ~dec_ok & ~dec_blank);

        digits_d = digits_q;
        dok_d    = dok_q;
`ifdef SEVEN_SEGMENT_READER_DP_EN
        dp_d     = dp_q;
`endif
        valid_d  = valid_q & ~out_ready;
        ovr_d    = ovr_q;
        if (load) begin
            digits_d = slot_d;
            dok_d    = sok_d;
`ifdef SEVEN_SEGMENT_READER_DP_EN
            dp_d     = sdp_d;
`endif
            valid_d  = 1'b1;
            // Loading over an accepted frame is not an overrun
            ovr_d    = ovr_q | (valid_q & ~out_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '1;
            s2_q     <= '1;
            prev_q   <= '1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            slot_q   <= {NUM_DIGITS{DIGIT_INVALID}};
            sok_q    <= '0;
            digits_q <= {NUM_DIGITS{DIGIT_INVALID}};
            dok_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
`ifdef SEVEN_SEGMENT_READER_DP_EN
            sdp_q    <= '0;
            dp_q     <= '0;
`endif
        end else begin
            s1_q     <= in_raw;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            slot_q   <= slot_d;
            sok_q    <= sok_d;
            digits_q <= digits_d;
            dok_q    <= dok_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
`ifdef SEVEN_SEGMENT_READER_DP_EN
            sdp_q    <= sdp_d;
            dp_q     <= dp_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign digit_ok    = dok_q;
    assign out_valid   = valid_q;
    assign overrun     = ovr_q;
    assign pattern_err = perr_q;
`ifdef SEVEN_SEGMENT_READER_DP_EN
    assign dp          = dp_q;
`endif

endmodule
